// File: rtl/trace_capture_buf.sv
// Circular probe trace buffer with masked/edge/external trigger and post-trigger count.
// Capture writes take 0 cycles (registered status next edge); read port has 1-cycle latency; no backpressure.
module trace_capture_buf #(
   parameter int C_DATA_WIDTH = 192,
   parameter int C_DEPTH_LOG2 = 10
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [C_DATA_WIDTH-1:0]   din,
   input  logic                      sample_en,
   input  logic [C_DATA_WIDTH-1:0]   trig_value,
   input  logic [C_DATA_WIDTH-1:0]   trig_mask,
   input  logic [1:0]                trig_mode,
   input  logic                      trig_ext,
   input  logic [C_DEPTH_LOG2-1:0]   post_len,
   input  logic                      arm,
   input  logic                      abort,
   output logic                      busy,
   output logic                      done,
   output logic                      trig_out,
   output logic [C_DEPTH_LOG2-1:0]   trig_addr,
   output logic [C_DEPTH_LOG2-1:0]   start_addr,
   output logic [C_DEPTH_LOG2:0]     fill_cnt,
   input  logic                      rd_en,
   input  logic [C_DEPTH_LOG2-1:0]   rd_addr,
   output logic [C_DATA_WIDTH-1:0]   rd_data
);

   localparam int DEPTH = 2 ** C_DEPTH_LOG2;
   localparam logic [C_DEPTH_LOG2:0] FULL = {1'b1, {C_DEPTH_LOG2{1'b0}}};

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CAPTURE = 2'd1,
      POST    = 2'd2,
      DONE    = 2'd3
   } state_t;

   state_t                    state_q, state_d;
   logic [C_DEPTH_LOG2-1:0]   wr_ptr_q, wr_ptr_d;
   logic [C_DEPTH_LOG2:0]     fill_q, fill_d;
   logic [C_DEPTH_LOG2-1:0]   trig_addr_q, trig_addr_d;
   logic [C_DEPTH_LOG2-1:0]   start_addr_q, start_addr_d;
   logic [C_DEPTH_LOG2-1:0]   remain_q, remain_d;
   logic                      match_hist_q, match_hist_d;
   logic                      trig_out_q, trig_out_d;
   logic [C_DATA_WIDTH-1:0]   rd_data_q;
   logic                      wr_en;
   logic                      match;
   logic                      trigger;

   logic [C_DATA_WIDTH-1:0]   mem_q [DEPTH];

   assign match = ((din ^ trig_value) & trig_mask) == '0;

   always_comb begin
      trigger = 1'b0;
      unique case (trig_mode)
         2'd0: trigger = match;
         2'd1: trigger = match & ~match_hist_q;
         2'd2: trigger = trig_ext;
         default: trigger = match | trig_ext;
      endcase
      trigger = trigger & sample_en;
   end

   always_comb begin
      state_d      = state_q;
      wr_ptr_d     = wr_ptr_q;
      fill_d       = fill_q;
      trig_addr_d  = trig_addr_q;
      start_addr_d = start_addr_q;
      remain_d     = remain_q;
      match_hist_d = sample_en ? match : match_hist_q;
      trig_out_d   = 1'b0;
      wr_en        = 1'b0;

      if (abort) begin
         state_d = IDLE;
      end else begin
         unique case (state_q)
            IDLE, DONE: begin
               if (arm) begin
                  state_d      = CAPTURE;
                  wr_ptr_d     = '0;
                  fill_d       = '0;
                  trig_addr_d  = '0;
                  start_addr_d = '0;
                  remain_d     = post_len;
                  // Edge history primed high so the first sample cannot edge-trigger.
                  match_hist_d = 1'b1;
               end
            end
            CAPTURE, POST: begin
               if (sample_en) begin
                  wr_en    = 1'b1;
                  wr_ptr_d = wr_ptr_q + 1'b1;
                  fill_d   = (fill_q == FULL) ? FULL : fill_q + 1'b1;
                  if (state_q == CAPTURE) begin
                     if (trigger) begin
                        trig_addr_d = wr_ptr_q;
                        trig_out_d  = 1'b1;
                        state_d     = (remain_q == '0) ? DONE : POST;
                     end
                  end else begin
                     remain_d = remain_q - 1'b1;
                     if (remain_q == 1) begin
                        state_d = DONE;
                     end
                  end
                  if (state_d == DONE) begin
                     start_addr_d = (fill_d == FULL) ? wr_ptr_d : '0;
                  end
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         wr_ptr_q     <= '0;
         fill_q       <= '0;
         trig_addr_q  <= '0;
         start_addr_q <= '0;
         remain_q     <= '0;
         match_hist_q <= 1'b1;
         trig_out_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         wr_ptr_q     <= wr_ptr_d;
         fill_q       <= fill_d;
         trig_addr_q  <= trig_addr_d;
         start_addr_q <= start_addr_d;
         remain_q     <= remain_d;
         match_hist_q <= match_hist_d;
         trig_out_q   <= trig_out_d;
      end
   end

   // Storage is left unreset so it maps onto block RAM.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[wr_ptr_q] <= din;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_data_q <= '0;
      end else if (rd_en) begin
         rd_data_q <= mem_q[rd_addr];
      end
   end

   assign busy       = (state_q == CAPTURE) || (state_q == POST);
   assign done       = (state_q == DONE);
   assign trig_out   = trig_out_q;
   assign trig_addr  = trig_addr_q;
   assign start_addr = start_addr_q;
   assign fill_cnt   = fill_q;
   assign rd_data    = rd_data_q;

endmodule

// File: tb/tb_trace_capture_buf.sv
// Directed bench for trace_capture_buf with 8-bit probe and 16-entry buffer.
module tb_trace_capture_buf;

   localparam int W  = 8;
   localparam int LG = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [W-1:0]  din = '0;
   logic          sample_en = 1'b0;
   logic [W-1:0]  trig_value = '0;
   logic [W-1:0]  trig_mask = '0;
   logic [1:0]    trig_mode = '0;
   logic          trig_ext = 1'b0;
   logic [LG-1:0] post_len = '0;
   logic          arm = 1'b0;
   logic          abort = 1'b0;
   logic          busy, done, trig_out;
   logic [LG-1:0] trig_addr, start_addr;
   logic [LG:0]   fill_cnt;
   logic          rd_en = 1'b0;
   logic [LG-1:0] rd_addr = '0;
   logic [W-1:0]  rd_data;

   int total = 0;
   int bad = 0;

   trace_capture_buf #(.C_DATA_WIDTH(W), .C_DEPTH_LOG2(LG)) dut (
      .clk(clk), .rst_n(rst_n), .din(din), .sample_en(sample_en),
      .trig_value(trig_value), .trig_mask(trig_mask), .trig_mode(trig_mode),
      .trig_ext(trig_ext), .post_len(post_len), .arm(arm), .abort(abort),
      .busy(busy), .done(done), .trig_out(trig_out), .trig_addr(trig_addr),
      .start_addr(start_addr), .fill_cnt(fill_cnt), .rd_en(rd_en),
      .rd_addr(rd_addr), .rd_data(rd_data)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [1:0] mode;
      logic [7:0] val;
      logic [7:0] mask;
      logic [7:0] d;
      logic       ext;
      logic       exp_trig;
   } trig_vec_t;

   typedef struct packed {
      logic [3:0] addr;
      logic [7:0] exp;
   } rd_vec_t;

   trig_vec_t tv[10];
   rd_vec_t   rv[6];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_abort();
      sample_en = 1'b0;
      abort = 1'b1;
      tick();
      abort = 1'b0;
   endtask

   task automatic do_arm(input logic [1:0] m, input logic [7:0] v, input logic [7:0] mk,
                         input logic [3:0] pl);
      sample_en  = 1'b0;
      trig_mode  = m;
      trig_value = v;
      trig_mask  = mk;
      post_len   = pl;
      arm = 1'b1;
      tick();
      arm = 1'b0;
   endtask

   task automatic sample(input logic [7:0] d, input logic en);
      din = d;
      sample_en = en;
      tick();
   endtask

   initial begin
      int trig_cnt, trig_at, done_at;

      tv[0] = '{2'd0, 8'h5A, 8'hFF, 8'h5A, 1'b0, 1'b1};
      tv[1] = '{2'd0, 8'h5A, 8'hF0, 8'h53, 1'b0, 1'b1};
      tv[2] = '{2'd0, 8'h5A, 8'hFF, 8'h5B, 1'b0, 1'b0};
      tv[3] = '{2'd1, 8'h5A, 8'hFF, 8'h5A, 1'b0, 1'b0};
      tv[4] = '{2'd2, 8'h00, 8'hFF, 8'h00, 1'b0, 1'b0};
      tv[5] = '{2'd2, 8'h00, 8'hFF, 8'h11, 1'b1, 1'b1};
      tv[6] = '{2'd3, 8'h5A, 8'hFF, 8'h5A, 1'b0, 1'b1};
      tv[7] = '{2'd3, 8'h5A, 8'hFF, 8'h00, 1'b1, 1'b1};
      tv[8] = '{2'd3, 8'h5A, 8'hFF, 8'h00, 1'b0, 1'b0};
      tv[9] = '{2'd0, 8'hC3, 8'h00, 8'h3C, 1'b0, 1'b1};

      rv[0] = '{4'd5,  8'h15};
      rv[1] = '{4'd0,  8'h20};
      rv[2] = '{4'd4,  8'h24};
      rv[3] = '{4'd6,  8'h16};
      rv[4] = '{4'd15, 8'h1F};
      rv[5] = '{4'd1,  8'h21};

      // Reset state
      tick();
      tick();
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_trig_out", trig_out, 0);
      chk("rst_trig_addr", trig_addr, 0);
      chk("rst_start_addr", start_addr, 0);
      chk("rst_fill", fill_cnt, 0);
      chk("rst_rd_data", rd_data, 0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();

      // Wrapping capture, level trigger on 0x20 with 4 post samples
      do_arm(2'd0, 8'h20, 8'hFF, 4'd4);
      chk("s1_busy_armed", busy, 1);
      trig_cnt = 0; trig_at = -1; done_at = -1;
      for (int i = 0; i < 48; i++) begin
         sample(8'(i), 1'b1);
         if (trig_out) begin
            trig_cnt++;
            trig_at = i;
         end
         if (done && done_at < 0) done_at = i;
      end
      sample_en = 1'b0;
      chk("s1_trig_cnt", trig_cnt, 1);
      chk("s1_trig_at", trig_at, 32'h20);
      chk("s1_done_at", done_at, 32'h24);
      chk("s1_trig_addr", trig_addr, 0);
      chk("s1_fill", fill_cnt, 16);
      chk("s1_start_addr", start_addr, 5);
      chk("s1_busy", busy, 0);
      for (int i = 0; i < 6; i++) begin
         rd_en = 1'b1;
         rd_addr = rv[i].addr;
         tick();
         chk($sformatf("s1_rd_%0d", rv[i].addr), rd_data, rv[i].exp);
      end
      rd_en = 1'b0;
      rd_addr = 4'd2;
      tick();
      chk("s1_rd_hold", rd_data, 8'h21);

      // Trigger mode/mask table, one qualified sample per entry
      for (int i = 0; i < 10; i++) begin
         do_abort();
         do_arm(tv[i].mode, tv[i].val, tv[i].mask, 4'd0);
         din = tv[i].d;
         trig_ext = tv[i].ext;
         sample_en = 1'b1;
         tick();
         sample_en = 1'b0;
         trig_ext = 1'b0;
         chk($sformatf("tv%0d_trig", i), trig_out, tv[i].exp_trig);
         chk($sformatf("tv%0d_done", i), done, tv[i].exp_trig);
      end

      // post_len 0: done right after the trigger sample
      do_abort();
      do_arm(2'd0, 8'h03, 8'hFF, 4'd0);
      for (int i = 0; i < 3; i++) sample(8'(i), 1'b1);
      chk("s2_not_done", done, 0);
      sample(8'h03, 1'b1);
      sample_en = 1'b0;
      chk("s2_done", done, 1);
      chk("s2_fill", fill_cnt, 4);
      chk("s2_start_addr", start_addr, 0);
      chk("s2_trig_addr", trig_addr, 3);

      // Edge mode: steady match never fires, re-match after a miss does
      do_abort();
      do_arm(2'd1, 8'h77, 8'hFF, 4'd0);
      trig_cnt = 0;
      for (int i = 0; i < 10; i++) begin
         sample(8'h77, 1'b1);
         if (trig_out) trig_cnt++;
      end
      sample(8'h00, 1'b1);
      if (trig_out) trig_cnt++;
      chk("s3_no_edge", trig_cnt, 0);
      sample(8'h77, 1'b1);
      sample_en = 1'b0;
      chk("s3_edge_trig", trig_out, 1);
      chk("s3_edge_addr", trig_addr, 11);

      // sample_en gaps during POST
      do_abort();
      do_arm(2'd0, 8'h40, 8'hFF, 4'd3);
      sample(8'h3E, 1'b1);
      sample(8'h3F, 1'b1);
      sample(8'h40, 1'b1);
      chk("s4_fill_trig", fill_cnt, 3);
      chk("s4_trig_addr", trig_addr, 2);
      sample(8'h41, 1'b1);
      chk("s4_fill_a", fill_cnt, 4);
      sample(8'hEE, 1'b0);
      chk("s4_fill_gap_a", fill_cnt, 4);
      sample(8'h42, 1'b1);
      chk("s4_fill_b", fill_cnt, 5);
      sample(8'hEE, 1'b0);
      chk("s4_fill_gap_b", fill_cnt, 5);
      chk("s4_busy_gap", busy, 1);
      sample(8'h43, 1'b1);
      sample_en = 1'b0;
      chk("s4_done", done, 1);
      chk("s4_fill_end", fill_cnt, 6);
      for (int i = 3; i < 6; i++) begin
         rd_en = 1'b1;
         rd_addr = 4'(i);
         tick();
         chk($sformatf("s4_rd_%0d", i), rd_data, 8'h41 + 8'(i - 3));
      end
      rd_en = 1'b0;

      // Abort during POST, arm+abort in IDLE, arm during CAPTURE
      do_abort();
      do_arm(2'd0, 8'h10, 8'hFF, 4'd5);
      sample(8'h10, 1'b1);
      sample(8'h11, 1'b1);
      chk("s5_busy_post", busy, 1);
      do_abort();
      chk("s5_abort_busy", busy, 0);
      chk("s5_abort_done", done, 0);
      arm = 1'b1;
      abort = 1'b1;
      tick();
      arm = 1'b0;
      abort = 1'b0;
      chk("s5_armabort_busy", busy, 0);
      do_arm(2'd0, 8'hAA, 8'hFF, 4'd8);
      for (int i = 0; i < 3; i++) sample(8'h00, 1'b1);
      chk("s5_fill3", fill_cnt, 3);
      arm = 1'b1;
      sample(8'h00, 1'b1);
      arm = 1'b0;
      chk("s5_arm_ignored", fill_cnt, 4);
      chk("s5_busy_still", busy, 1);

      // Asynchronous reset mid-POST
      sample(8'hAA, 1'b1);
      sample_en = 1'b0;
      chk("s6_trig_before_rst", trig_out, 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("s6_rst_busy", busy, 0);
      chk("s6_rst_done", done, 0);
      chk("s6_rst_trig", trig_out, 0);
      chk("s6_rst_fill", fill_cnt, 0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      do_arm(2'd0, 8'h01, 8'hFF, 4'd1);
      sample(8'h00, 1'b1);
      sample(8'h01, 1'b1);
      chk("s6_post_busy", busy, 1);
      sample(8'h02, 1'b1);
      sample_en = 1'b0;
      chk("s6_done", done, 1);
      chk("s6_fill", fill_cnt, 3);
      chk("s6_trig_addr", trig_addr, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/trace_capture_buf.md
Name: trace_capture_buf

Overview: Synthesizable in-fabric trace buffer that replaces the fixed-width black-box ILA used for SATA link/transport debug. It records a parametrised-width probe bus into a circular RAM, with a masked pattern trigger, edge and external trigger modes, and a programmable post-trigger length. It exposes a registered read port so the host register block can dump captures without vendor tools.

Parameters:
C_DATA_WIDTH, 192, probe bus width in bits
C_DEPTH_LOG2, 10, log2 of buffer depth (DEPTH = 2**C_DEPTH_LOG2)

Ports:
clk  in  1  capture and read clock
rst_n  in  1  asynchronous active-low reset
din  in  C_DATA_WIDTH  probe data
sample_en  in  1  qualifies din; no write, trigger evaluation or count change when 0
trig_value  in  C_DATA_WIDTH  pattern to match
trig_mask  in  C_DATA_WIDTH  1 = bit compared, 0 = don't care
trig_mode  in  2  0 level, 1 rising-edge of match, 2 external, 3 level OR external
trig_ext  in  1  external trigger, qualified by sample_en
post_len  in  C_DEPTH_LOG2  samples stored after the trigger sample; latched on arm
arm  in  1  single-cycle start pulse
abort  in  1  single-cycle stop pulse
busy  out  1  1 in CAPTURE or POST
done  out  1  1 in DONE
trig_out  out  1  one-cycle pulse, cycle after trigger accepted
trig_addr  out  C_DEPTH_LOG2  RAM address holding the trigger sample
start_addr  out  C_DEPTH_LOG2  address of oldest valid sample
fill_cnt  out  C_DEPTH_LOG2+1  valid samples, saturates at DEPTH
rd_en  in  1  read strobe
rd_addr  in  C_DEPTH_LOG2  read address
rd_data  out  C_DATA_WIDTH  RAM word, 1-cycle latency

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE. busy, done, trig_out, trig_addr, start_addr, fill_cnt, rd_data all 0; wr_ptr 0. RAM contents are not reset.
- match = ((din ^ trig_value) & trig_mask) == 0. Edge-mode history match_d updates only on sample_en and is set to 1 on arm, so the first sample cannot edge-trigger.
- trigger = sample_en AND (mode0: match; mode1: match & ~match_d; mode2: trig_ext; mode3: match | trig_ext).
- IDLE/DONE + arm: wr_ptr=0, fill_cnt=0, trig_addr=0, start_addr=0, done=0; latch post_len -> remaining. Go to CAPTURE.
- arm in CAPTURE/POST: ignored. abort in any state: go to IDLE, busy=0, done=0. abort wins over a simultaneous arm.
- CAPTURE, each sample_en:
  - write din at wr_ptr; wr_ptr increments modulo DEPTH; fill_cnt increments and saturates at DEPTH.
  - On trigger: trig_addr = wr_ptr (pre-increment); trig_out pulses next cycle. Next state is DONE if latched post_len == 0, else POST.
- POST, each sample_en: write as above, remaining decrements. The write taking remaining from 1 to 0 moves to DONE. Triggers are ignored.
- On entry to DONE (registered in the same edge): start_addr = final wr_ptr if fill_cnt == DEPTH, else 0. No writes in DONE. Outputs hold until arm, abort or reset.
- post_len max DEPTH-1 guarantees the trigger sample survives. Wrap is pure modulo.
- Read port: rd_en at cycle N gives rd_data = RAM[rd_addr] at N+1. rd_data holds when rd_en=0. Reads are legal in any state. A read of the address being written in the same cycle returns the old data (read-first).
- Single RAM instance, one write port and one read port, inferred as block RAM.

Test Plan:
- C_DEPTH_LOG2=4, mode0, mask=0xFF, value=0x20, post_len=4, din=sample index 0,1,2.. with sample_en=1 -> trig_out once after sample 0x20; done after sample 0x24; trig_addr=0, fill_cnt=16, start_addr=5; rd_addr 5 -> 0x15, rd_addr 0 -> 0x20, rd_addr 4 -> 0x24.
- post_len=0, trigger on sample 3 -> DONE the cycle after the sample 3 edge; fill_cnt=4, start_addr=0, trig_addr=3.
- mode1, din matching on every sample for 10 cycles -> no trigger. Then one non-matching sample, then a match -> trigger on that re-match.
- sample_en toggling 1/0 during POST with post_len=3 -> exactly 3 writes after the trigger; wr_ptr and remaining frozen on the 0 cycles.
- abort during POST -> busy=0, done=0 next cycle. Simultaneous arm+abort in IDLE -> stays IDLE. arm during CAPTURE -> ignored (fill_cnt not cleared).
- rst_n asserted mid-POST, asynchronously between clock edges -> busy, done, trig_out, fill_cnt go to 0 immediately. After release, arm restarts a clean capture.
